regfile_sb: RTL and testbench

- Parametrised successor register file for the y_risc integer pipeline.
- Generalised in data width and depth, with two writeback ports and two combinational read ports with optional write-to-read bypass.
- Adds a per-register pending-write scoreboard: issue allocates a destination, writeback releases it.
- Sits between decode/issue (read, allocate) and the writeback stages.

---
 rtl/regfile_sb.sv | 137 +++++++++++++
 tb/tb_regfile_sb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a pending-write scoreboard.
//   Two combinational read ports (A/B) with optional same-cycle writeback bypass,
//   two writeback ports (wb0 has priority on the same destination), and an issue
//   allocation port that marks a destination busy until its writeback arrives.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rd_{a,b}_addr_i/_data_o/_busy_o read address, data and pending-write flag
//   alloc_en_i, alloc_rd_i          allocation request and destination
//   alloc_ok_o                      allocation accepted this cycle
//   wb{0,1}_en_i/_rd_i/_data_i      writeback enables, destinations and data
//   busy_vec_o                      registered scoreboard bits (bit 0 always 0)
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       rd_a_addr_i,
    output logic [XLEN-1:0]     rd_a_data_o,
    output logic                rd_a_busy_o,
    input  logic [AW-1:0]       rd_b_addr_i,
    output logic [XLEN-1:0]     rd_b_data_o,
    output logic                rd_b_busy_o,
    input  logic                alloc_en_i,
    input  logic [AW-1:0]       alloc_rd_i,
    output logic                alloc_ok_o,
    input  logic                wb0_en_i,
    input  logic [AW-1:0]       wb0_rd_i,
    input  logic [XLEN-1:0]     wb0_data_i,
    input  logic                wb1_en_i,
    input  logic [AW-1:0]       wb1_rd_i,
    input  logic [XLEN-1:0]     wb1_data_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Writebacks that actually target a real register (x0 writes are dropped).
    logic wb0_live;
    logic wb1_live;
    assign wb0_live = wb0_en_i && (wb0_rd_i != '0);
    assign wb1_live = wb1_en_i && (wb1_rd_i != '0);

    // Read lookup: returns {busy, data} for one port, including bypass.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] addr);
        logic hit0;
        logic hit1;
        logic [XLEN-1:0] data;
        logic bsy;
        hit0 = wb0_live && (wb0_rd_i == addr);
        hit1 = wb1_live && (wb1_rd_i == addr);
        data = regs[addr];
        bsy  = busy_q[addr];
        if (BYPASS && hit0) begin
            data = wb0_data_i;
        end else if (BYPASS && hit1) begin
            data = wb1_data_i;
        end
        if (BYPASS && (hit0 || hit1)) begin
            bsy = 1'b0;
        end
        if (addr == '0) begin
            data = '0;
            bsy  = 1'b0;
        end
        return {bsy, data};
    endfunction

    // Read ports; forced to zero while reset is held so bypass cannot leak data.
    always_comb begin
        rd_a_data_o = '0;
        rd_a_busy_o = 1'b0;
        rd_b_data_o = '0;
        rd_b_busy_o = 1'b0;
        if (!rst) begin
            {rd_a_busy_o, rd_a_data_o} = lookup(rd_a_addr_i);
            {rd_b_busy_o, rd_b_data_o} = lookup(rd_b_addr_i);
        end
    end

    // Allocation accepted when the destination is free or is being retired now.
    always_comb begin
        alloc_ok_o = 1'b0;
        if (!rst && alloc_en_i) begin
            alloc_ok_o = (alloc_rd_i == '0) || !busy_q[alloc_rd_i]
                      || (wb0_en_i && (wb0_rd_i == alloc_rd_i))
                      || (wb1_en_i && (wb1_rd_i == alloc_rd_i));
        end
    end

    // Scoreboard next state: writebacks release, then a new allocation re-sets.
    always_comb begin
        busy_d = busy_q;
        if (wb1_live) begin
            busy_d[wb1_rd_i] = 1'b0;
        end
        if (wb0_live) begin
            busy_d[wb0_rd_i] = 1'b0;
        end
        if (alloc_ok_o && (alloc_rd_i != '0)) begin
            busy_d[alloc_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register array; wb0 wins when both ports hit the same destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb0_en_i && (wb0_rd_i == AW'(i))) begin
                    regs[i] <= wb0_data_i;
                end else if (wb1_en_i && (wb1_rd_i == AW'(i))) begin
                    regs[i] <= wb1_data_i;
                end
            end
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share the same stimulus so both read behaviours are checked side by side.
module tb_regfile_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   rd_a_addr = '0;
    logic [AW-1:0]   rd_b_addr = '0;
    logic            alloc_en = 1'b0;
    logic [AW-1:0]   alloc_rd = '0;
    logic            wb0_en = 1'b0;
    logic [AW-1:0]   wb0_rd = '0;
    logic [XLEN-1:0] wb0_data = '0;
    logic            wb1_en = 1'b0;
    logic [AW-1:0]   wb1_rd = '0;
    logic [XLEN-1:0] wb1_data = '0;

    logic [XLEN-1:0] y_a_data, y_b_data, n_a_data, n_b_data;
    logic            y_a_busy, y_b_busy, n_a_busy, n_b_busy;
    logic            y_ok, n_ok;
    logic [NREG-1:0] y_vec, n_vec;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NREG), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .rd_a_addr_i(rd_a_addr), .rd_a_data_o(y_a_data), .rd_a_busy_o(y_a_busy),
        .rd_b_addr_i(rd_b_addr), .rd_b_data_o(y_b_data), .rd_b_busy_o(y_b_busy),
        .alloc_en_i(alloc_en), .alloc_rd_i(alloc_rd), .alloc_ok_o(y_ok),
        .wb0_en_i(wb0_en), .wb0_rd_i(wb0_rd), .wb0_data_i(wb0_data),
        .wb1_en_i(wb1_en), .wb1_rd_i(wb1_rd), .wb1_data_i(wb1_data),
        .busy_vec_o(y_vec)
    );

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NREG), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst),
        .rd_a_addr_i(rd_a_addr), .rd_a_data_o(n_a_data), .rd_a_busy_o(n_a_busy),
        .rd_b_addr_i(rd_b_addr), .rd_b_data_o(n_b_data), .rd_b_busy_o(n_b_busy),
        .alloc_en_i(alloc_en), .alloc_rd_i(alloc_rd), .alloc_ok_o(n_ok),
        .wb0_en_i(wb0_en), .wb0_rd_i(wb0_rd), .wb0_data_i(wb0_data),
        .wb1_en_i(wb1_en), .wb1_rd_i(wb1_rd), .wb1_data_i(wb1_data),
        .busy_vec_o(n_vec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_en = 1'b0;
        wb0_en   = 1'b0;
        wb1_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with a pending x5 writeback on the inputs.
        wb0_en = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEAD_BEEF;
        rd_a_addr = 5'd5; rd_b_addr = 5'd5;
        tick();
        check("rst_byp_a_data", y_a_data, 32'h0);
        check("rst_byp_a_busy", 32'(y_a_busy), 32'h0);
        check("rst_nob_b_data", n_b_data, 32'h0);
        check("rst_busy_vec", 32'(y_vec), 32'h0);
        rst = 1'b0; idle();
        tick();
        check("post_rst_x5", y_a_data, 32'h0);
        check("post_rst_vec", 32'(y_vec), 32'h0);

        // Write to x0 is ignored, never bypassed.
        wb0_en = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h0000_1234; rd_a_addr = 5'd0;
        #1;
        check("x0_bypass", y_a_data, 32'h0);
        tick(); idle();
        check("x0_read", y_a_data, 32'h0);
        check("x0_busy", 32'(y_a_busy), 32'h0);

        // Same-destination writebacks: wb0 wins.
        wb0_en = 1'b1; wb0_rd = 5'd7; wb0_data = 32'hAAAA_0000;
        wb1_en = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h5555_FFFF;
        rd_a_addr = 5'd7; rd_b_addr = 5'd7;
        #1;
        check("prio_byp_same", y_a_data, 32'hAAAA_0000);
        check("prio_nob_same", n_a_data, 32'h0);
        tick(); idle();
        check("prio_byp_a", y_a_data, 32'hAAAA_0000);
        check("prio_byp_b", y_b_data, 32'hAAAA_0000);
        check("prio_nob_a", n_a_data, 32'hAAAA_0000);
        check("prio_nob_b", n_b_data, 32'hAAAA_0000);

        // Bypass from wb1 onto port A.
        wb0_en = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h11;
        tick(); idle();
        wb1_en = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h22; rd_a_addr = 5'd3;
        #1;
        check("byp_data", y_a_data, 32'h22);
        check("byp_busy", 32'(y_a_busy), 32'h0);
        check("nobyp_data", n_a_data, 32'h11);
        tick(); idle();
        check("nobyp_next", n_a_data, 32'h22);

        // Scoreboard allocate / reject / release on x9.
        alloc_en = 1'b1; alloc_rd = 5'd9; rd_b_addr = 5'd9;
        #1;
        check("alloc9_ok", 32'(y_ok), 32'h1);
        tick();
        check("alloc9_vec", 32'(y_vec), 32'h0000_0200);
        check("alloc9_rdb_busy", 32'(y_b_busy), 32'h1);
        check("alloc9_again", 32'(y_ok), 32'h0);
        check("alloc9_again_nob", 32'(n_ok), 32'h0);
        idle();
        #1;
        check("alloc_off_ok", 32'(y_ok), 32'h0);
        wb0_en = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99;
        #1;
        check("wb9_byp_busy", 32'(y_b_busy), 32'h0);
        check("wb9_byp_data", y_b_data, 32'h99);
        check("wb9_nob_busy", 32'(n_b_busy), 32'h1);
        tick(); idle();
        check("wb9_vec", 32'(y_vec), 32'h0);
        check("wb9_read", n_b_data, 32'h99);

        // Allocation of x0 is accepted and sets nothing.
        alloc_en = 1'b1; alloc_rd = 5'd0;
        #1;
        check("alloc0_ok", 32'(y_ok), 32'h1);
        tick(); idle();
        check("alloc0_vec", 32'(y_vec), 32'h0);

        // Allocate and writeback x4 in the same cycle: new allocation wins.
        alloc_en = 1'b1; alloc_rd = 5'd4;
        tick(); idle();
        check("x4_busy", 32'(y_vec), 32'h0000_0010);
        alloc_en = 1'b1; alloc_rd = 5'd4;
        wb1_en = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h44;
        #1;
        check("coll_ok", 32'(y_ok), 32'h1);
        tick(); idle();
        rd_a_addr = 5'd4;
        #1;
        check("coll_vec", 32'(y_vec), 32'h0000_0010);
        check("coll_data", y_a_data, 32'h44);
        check("coll_busy", 32'(y_a_busy), 32'h1);

        // Asynchronous reset between edges with x4 and x10 busy.
        alloc_en = 1'b1; alloc_rd = 5'd10;
        tick(); idle();
        check("x10_vec", 32'(y_vec), 32'h0000_0410);
        #1;
        rst = 1'b1;
        #1;
        check("arst_vec", 32'(y_vec), 32'h0);
        check("arst_data", y_a_data, 32'h0);
        check("arst_busy", 32'(y_a_busy), 32'h0);
        rst = 1'b0;
        tick();
        rd_a_addr = 5'd10; rd_b_addr = 5'd7;
        #1;
        check("arst_post_vec", 32'(y_vec), 32'h0);
        check("arst_post_x10", y_a_data, 32'h0);
        check("arst_post_x7", y_b_data, 32'h0);
        check("arst_post_x10_busy", 32'(n_a_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
